byte_serial_adder: RTL and testbench

//  Multi-cycle wide adder built on one 8-bit carry-lookahead slice (eightbitfastadder).

---
 rtl/alu_pkg.sv | 27 ++
 rtl/eightbitfastadder.sv | 43 ++++
 rtl/byte_serial_adder.sv | 144 ++++++++++++++
 tb/tb_byte_serial_adder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: FSM state encoding, slice width and
// the index-width helper used by the byte-serial adder.
package alu_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    BSA_IDLE,
    BSA_RUN,
    BSA_DONE
  } bsa_state_t;

  // Bits needed to index 'value' items (minimum 1 for value <= 2).
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    if (bits == 0) bits = 1;
    return bits;
  endfunction

endpackage

// File: rtl/eightbitfastadder.sv
// 8-bit carry-lookahead adder slice. Purely combinational; each carry is
// formed directly from generate/propagate terms rather than rippled.
module eightbitfastadder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] gen;
  logic [7:0] prop;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Carry into bit 'pos': OR of every generate term that can propagate up to
  // 'pos', plus the incoming carry when the whole lower run propagates.
  function automatic logic carry_into(input int pos, input logic [7:0] g,
                                      input logic [7:0] p, input logic c0);
    logic c_acc;
    logic p_run;
    c_acc = 1'b0;
    p_run = 1'b1;
    for (int j = pos - 1; j >= 0; j--) begin
      c_acc = c_acc | (p_run & g[j]);
      p_run = p_run & p[j];
    end
    return c_acc | (p_run & c0);
  endfunction

  // Sum bits and carry-out from the lookahead carries.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    sum  = '0;
    cout = carry_into(8, gen, prop, cin);
    for (int i = 0; i < 8; i++) begin
      sum[i] = prop[i] ^ carry_into(i, gen, prop, cin);
    end
  end

endmodule

// File: rtl/byte_serial_adder.sv
// Multi-cycle WIDTH-bit adder: latches both operands, pushes one byte per
// cycle (LSB first) through a single 8-bit lookahead slice, carries between
// bytes in a register and reports carry/overflow/zero/negative flags.
// Optional subtract support is compiled in with BYTE_SERIAL_SUB_EN.
module byte_serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  bsa_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;

  logic [WIDTH-1:0] b_load;
  logic             cin_load;
  logic [7:0]       slice_sum;
  logic             slice_cout;

`ifdef BYTE_SERIAL_SUB_EN
  // Subtract as a + ~b + 1: invert b when latching and seed the carry with 1.
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_load     = b;
  assign cin_load   = 1'b0;
`endif

  eightbitfastadder u_slice (
    .a    (a_q[idx_q*SLICE_W +: SLICE_W]),
    .b    (b_q[idx_q*SLICE_W +: SLICE_W]),
    .cin  (cin_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state, operand latch, byte write-back and flag computation.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cin_d      = cin_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    case (state_q)
      BSA_IDLE, BSA_DONE: begin
        if (start) begin
          state_d = BSA_RUN;
          a_d     = a;
          b_d     = b_load;
          idx_d   = '0;
          cin_d   = cin_load;
        end else begin
          state_d = BSA_IDLE;
        end
      end
      BSA_RUN: begin
        result_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
        cin_d = slice_cout;
        if (idx_q == IDX_LAST) begin
          // Index is held at its last value; it is re-zeroed on the next accept.
          state_d    = BSA_DONE;
          carry_d    = slice_cout;
          overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (result_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d     = (result_d == '0);
          negative_d = result_d[WIDTH-1];
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = BSA_IDLE;
    endcase
  end

  // State, datapath and flag registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BSA_IDLE;
      idx_q      <= '0;
      cin_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking would make results depend on statement order.
      state_q    <= state_d;
      idx_q      <= idx_d;
      cin_q      <= cin_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  assign busy     = (state_q == BSA_RUN);
  assign done     = (state_q == BSA_DONE);
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed bench for byte_serial_adder (WIDTH=32) with an expected-result
// scoreboard filled at launch and drained when done pulses.
module tb_byte_serial_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         negative;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   seen_done;

  byte_serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one wide addition, subtract only when the feature is built in.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t         e;
    logic [W-1:0] yy;
    logic         c0;
    logic [W:0]   full;
`ifdef BYTE_SERIAL_SUB_EN
    yy = s ? ~y : y;
    c0 = s;
`else
    yy = y;
    c0 = 1'b0;
`endif
    full  = {1'b0, x} + {1'b0, yy} + (W + 1)'(c0);
    e.res = full[W-1:0];
    e.c   = full[W];
    e.v   = (x[W-1] == yy[W-1]) && (e.res[W-1] != x[W-1]);
    e.z   = (e.res == '0);
    e.n   = e.res[W-1];
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    a     = x;
    b     = y;
    sub   = s;
    start = 1'b1;
    sb.push_back(model(x, y, s));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", W'(busy), W'(1'b1));
  endtask

  // Waits (bounded) for done, checks latency/busy length, then scores result.
  task automatic finish_op(input string tag, input bit inject);
    int   edges;
    int   busy_cnt;
    exp_t e;
    edges    = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && edges < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (inject && edges == 2) begin
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check({tag, "_latency"}, W'(edges), W'(5));
    check({tag, "_busy_cycles"}, W'(busy_cnt), W'(4));
    check({tag, "_busy_in_done"}, W'(busy), W'(1'b0));
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, W'(1), W'(0));
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, result, e.res);
      check({tag, "_carry"}, W'(carry), W'(e.c));
      check({tag, "_overflow"}, W'(overflow), W'(e.v));
      check({tag, "_zero"}, W'(zero), W'(e.z));
      check({tag, "_negative"}, W'(negative), W'(e.n));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_done", W'(done), W'(1'b0));
    check("rst_result", result, '0);
    check("rst_carry", W'(carry), W'(1'b0));
    check("rst_overflow", W'(overflow), W'(1'b0));
    check("rst_zero", W'(zero), W'(1'b0));
    check("rst_negative", W'(negative), W'(1'b0));
    reset = 1'b0;
    @(negedge clk);

    // Basic add with a byte-crossing carry.
    launch(32'h0000_00FF, 32'h0000_0001, 1'b0);
    finish_op("ff_plus_1", 1'b0);
    check("ff_plus_1_const", result, 32'h0000_0100);
    @(negedge clk);
    check("done_one_cycle", W'(done), W'(1'b0));
    check("idle_busy", W'(busy), W'(1'b0));
    check("idle_result_held", result, 32'h0000_0100);

    // Full-width carry out, zero result.
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    finish_op("all_ones_plus_1", 1'b0);
    check("all_ones_zero_const", W'(zero), W'(1'b1));
    @(negedge clk);

    // Signed overflow into the sign bit.
    launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    finish_op("max_pos_plus_1", 1'b0);
    check("max_pos_result_const", result, 32'h8000_0000);
    @(negedge clk);

    // Start pulsed mid-RUN with different operands must be ignored.
    launch(32'h1234_5678, 32'h1111_1111, 1'b0);
    finish_op("ignore_start", 1'b1);
    @(negedge clk);
    check("ignore_no_queue_busy", W'(busy), W'(1'b0));
    check("ignore_no_queue_done", W'(done), W'(1'b0));
    check("ignore_result_held", result, 32'h2345_6789);

    // Back-to-back: second start driven in the DONE cycle.
    launch(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
    finish_op("b2b_first", 1'b0);
    launch(32'h8000_0000, 32'h8000_0000, 1'b0);
    finish_op("b2b_second", 1'b0);
    @(negedge clk);

    // Subtract request: honoured only when the feature is compiled in.
    launch(32'd5, 32'd7, 1'b1);
    finish_op("sub_5_7", 1'b0);
`ifdef BYTE_SERIAL_SUB_EN
    check("sub_5_7_const", result, 32'hFFFF_FFFE);
`else
    check("sub_5_7_const", result, 32'd12);
`endif
    @(negedge clk);

    // A few random operations, random sub.
    for (int i = 0; i < 3; i++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      finish_op("random", 1'b0);
      @(negedge clk);
    end

    // Reset in the second RUN cycle aborts the operation.
    launch(32'h0102_0304, 32'h1020_3040, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", W'(busy), W'(1'b0));
    check("abort_done", W'(done), W'(1'b0));
    check("abort_result", result, '0);
    check("abort_flags", W'({carry, overflow, zero, negative}), W'(4'b0000));
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    reset     = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", W'(seen_done), W'(1'b0));
    check("abort_idle_busy", W'(busy), W'(1'b0));
    check("abort_idle_result", result, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
